vote_result_reporter: RTL and testbench
=======================================

# vote_result_reporter

Reads the four 8-bit candidate tallies produced by the vote logger and transmits them as a framed byte stream over a valid/ready interface. Frames go to a host link or display serializer. The block sits beside the LED mode controller in result mode (mode=1). It snapshots the tallies, computes the winner and tie status while sending, and appends an XOR checksum.

## Interface
Parameters:
- HEADER, 8'hA5, first byte of every frame

Ports:
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- mode  input  1  0 = voting, 1 = result; requests accepted only when 1
- report_req  input  1  single-cycle request to send one frame
- cand1_vote, cand2_vote, cand3_vote, cand4_vote  input  8 each  live tallies from the vote logger
- tx_data  output  8  current frame byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both high on a rising edge
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse after the last byte is accepted
- winner  output  2  0-based index of the winning candidate from the last completed frame
- tie  output  1  the last completed frame had more than one candidate at the maximum

## Operation
- States:
  - IDLE: waits for a request.
  - SEND: byte index idx runs 0..6.
  - DONE: lasts one cycle, then returns to IDLE.
- IDLE → SEND when report_req=1 and mode=1 at a rising edge:
  - the four tallies are captured into snapshot registers;
  - idx is set to 0, the running max is cleared, and the running checksum is cleared.
- report_req is ignored when mode=0 or when the state is not IDLE. Requests are not queued.
- Frame contents, in order:
  - byte 0: HEADER
  - bytes 1–4: snapshot counts for cand1..cand4
  - byte 5: status {tie, 5'b0, winner[1:0]}
  - byte 6: checksum, the XOR of bytes 0–5
- Winner tracking happens as each count byte k (k = 0..3, candidate index) is accepted:
  - if count > max: set max = count, set the running winner to k, clear the running tie.
  - if count == max: set the running tie.
  - max starts at 0 with running winner 0 and running tie 0. A count of 0 for candidate 0 therefore sets the running tie.
  - As a result, the lowest index wins among equal maxima, and all-zero tallies give winner=0, tie=1.
- Status byte: built from the running winner and running tie after byte 4 is accepted.
- Checksum: accumulated with XOR on each accepted byte 0–5.
- SEND → DONE when byte 6 is accepted. In DONE, the winner/tie output registers load from the running values.
- Once accepted, a frame always completes. Mode falling to 0 mid-frame does not abort it.
- Live tally changes after capture are not reflected in the frame in progress.

## Timing
- Reset (asynchronous, while reset=0) forces:
  - outputs tx_valid=0, busy=0, done=0, tx_data=8'h00, winner=0, tie=0;
  - state IDLE, with idx, max and checksum cleared.
- Reset asserted mid-frame drops tx_valid immediately, and the partial frame is abandoned. After reset release, the block waits in IDLE for a new request.
- Request at edge N: tx_valid=1 and tx_data=HEADER from after edge N, and busy=1 from the same cycle.
- Each byte is transferred at an edge where tx_valid & tx_ready. The next byte is presented in the following cycle, so a fully ready sink takes 7 consecutive cycles.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid are held stable. tx_valid never deasserts before acceptance.
- tx_valid stays high through the frame with no bubbles when tx_ready is held high.
- After the edge accepting byte 6:
  - tx_valid=0 and busy=0;
  - done=1 for exactly one cycle;
  - winner/tie update in that same cycle.
- A report_req arriving in the done cycle is ignored. The earliest new request is sampled in the cycle after done.
- Request-to-done latency is 8 cycles with tx_ready held at 1.

## Test plan
- Tie case: mode=1, counts 3,7,2,7, report_req pulse, tx_ready=1 → frame A5 03 07 02 07 81 25, done in cycle 8, winner=1, tie=1.
- Clear winner: counts 0,0,9,1 → frame A5 00 00 09 01 02 AF, winner=2, tie=0.
- Backpressure: counts 3,7,2,7 with tx_ready=0 for 5 cycles while byte 2 (0x07) is presented → tx_data stays 0x07 and tx_valid stays 1 throughout; frame and checksum unchanged.
- Snapshot and mode independence:
  - Changing cand1_vote from 3 to 200 mid-frame → byte 1 is still 0x03.
  - report_req with mode=0 → no tx_valid and busy stays 0.
  - Second report_req while busy → ignored; exactly one frame is sent.
- All-zero tallies → frame A5 00 00 00 00 80 25, winner=0, tie=1.
- Reset mid-frame: assert reset=0 while byte 3 is pending → tx_valid and busy drop asynchronously. After release, a new request sends a full, correct frame starting with A5.

Source files
------------

// File: rtl/vote_result_reporter_if.sv
// Byte-stream valid/ready link carrying vote report frames.
interface vote_result_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/vote_result_reporter.sv
// Snapshots four vote tallies and streams a 7-byte frame:
// header, counts, {tie,winner} status, XOR checksum.
module vote_result_reporter #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mode,
    input  logic                           report_req,
    input  logic [7:0]                     cand1_vote,
    input  logic [7:0]                     cand2_vote,
    input  logic [7:0]                     cand3_vote,
    input  logic [7:0]                     cand4_vote,
    vote_result_reporter_if.master         tx,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     winner,
    output logic                           tie
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      idx;
    logic [3:0][7:0] snap;
    logic [7:0]      max_q;
    logic [7:0]      csum;
    logic [1:0]      run_win;
    logic            run_tie;

    logic            start;
    logic            xfer;
    logic            last;
    logic [7:0]      byte_d;
    logic [1:0]      k;
    logic [7:0]      cnt;
    logic            is_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        byte_d   = 8'h00;
        start    = 1'b0;
        xfer     = 1'b0;
        last     = 1'b0;
        k        = idx[1:0] - 2'd1;
        cnt      = snap[k];
        is_count = (idx >= 3'd1) && (idx <= 3'd4);
        case (state)
            IDLE: begin
                if (report_req && mode) begin
                    start    = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                case (idx)
                    3'd0:    byte_d = HEADER;
                    3'd1,
                    3'd2,
                    3'd3,
                    3'd4:    byte_d = cnt;
                    3'd5:    byte_d = {run_tie, 5'b0, run_win};
                    default: byte_d = csum;
                endcase
                xfer = tx.tx_ready;
                last = xfer && (idx == 3'd6);
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign tx.tx_data  = byte_d;
    assign tx.tx_valid = (state == SEND);
    assign busy        = (state == SEND);
    assign done        = (state == DONE);

    // Winner/tie outputs load on the edge accepting the checksum,
    // so they are already valid during the done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx     <= 3'd0;
            snap    <= '0;
            max_q   <= 8'h00;
            csum    <= 8'h00;
            run_win <= 2'd0;
            run_tie <= 1'b0;
            winner  <= 2'd0;
            tie     <= 1'b0;
        end else if (start) begin
            snap    <= {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
            idx     <= 3'd0;
            max_q   <= 8'h00;
            csum    <= 8'h00;
            run_win <= 2'd0;
            run_tie <= 1'b0;
        end else if (xfer) begin
            idx <= last ? 3'd0 : idx + 3'd1;
            if (!last) begin
                csum <= csum ^ byte_d;
            end
            if (is_count) begin
                if (cnt > max_q) begin
                    max_q   <= cnt;
                    run_win <= k;
                    run_tie <= 1'b0;
                end else if (cnt == max_q) begin
                    run_tie <= 1'b1;
                end
            end
            if (last) begin
                winner <= run_win;
                tie    <= run_tie;
            end
        end
    end

endmodule

// File: tb/tb_vote_result_reporter.sv
// Directed bench for vote_result_reporter: frames, backpressure,
// request filtering, snapshotting and asynchronous reset.
module tb_vote_result_reporter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       report_req = 1'b0;
    logic [7:0] c1 = 8'h00;
    logic [7:0] c2 = 8'h00;
    logic [7:0] c3 = 8'h00;
    logic [7:0] c4 = 8'h00;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       tie;

    int checks = 0;
    int errors = 0;

    vote_result_reporter_if bus ();

    always #5 clock = ~clock;

    vote_result_reporter #(
        .HEADER(8'hA5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .report_req (report_req),
        .cand1_vote (c1),
        .cand2_vote (c2),
        .cand3_vote (c3),
        .cand4_vote (c4),
        .tx         (bus),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .tie        (tie)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flag: 1 = extra request mid-frame, 2 = mode drops mid-frame
    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic [55:0] f, input int stall_at,
                         input int stall_n, input int flag,
                         input logic [1:0] ew, input logic et);
        logic [7:0] eb;
        c1 = a;
        c2 = b;
        c3 = c;
        c4 = d;
        mode = 1'b1;
        bus.tx_ready = 1'b1;
        report_req = 1'b1;
        @(negedge clock);
        report_req = 1'b0;
        c1 = 8'd200;
        c2 = 8'd200;
        c3 = 8'd200;
        c4 = 8'd200;
        for (int i = 0; i < 7; i++) begin
            eb = f[55-8*i -: 8];
            report_req = (flag == 1) && (i == 3);
            if (flag == 2 && i == 1) mode = 1'b0;
            if (i == stall_at) begin
                bus.tx_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk("stall_valid", {7'b0, bus.tx_valid}, 8'h01);
                    chk("stall_data", bus.tx_data, eb);
                    @(negedge clock);
                end
                bus.tx_ready = 1'b1;
            end
            chk("valid", {7'b0, bus.tx_valid}, 8'h01);
            chk("busy", {7'b0, busy}, 8'h01);
            chk($sformatf("byte%0d", i), bus.tx_data, eb);
            @(negedge clock);
        end
        report_req = 1'b0;
        mode = 1'b1;
        chk("done", {7'b0, done}, 8'h01);
        chk("done_valid", {7'b0, bus.tx_valid}, 8'h00);
        chk("done_busy", {7'b0, busy}, 8'h00);
        chk("winner", {6'b0, winner}, {6'b0, ew});
        chk("tie", {7'b0, tie}, {7'b0, et});
        report_req = 1'b1;
        @(negedge clock);
        report_req = 1'b0;
        chk("done_pulse", {7'b0, done}, 8'h00);
        chk("post_valid", {7'b0, bus.tx_valid}, 8'h00);
        @(negedge clock);
        chk("idle_valid", {7'b0, bus.tx_valid}, 8'h00);
        chk("idle_busy", {7'b0, busy}, 8'h00);
    endtask

    initial begin
        bus.tx_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_valid", {7'b0, bus.tx_valid}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        chk("rst_data", bus.tx_data, 8'h00);
        chk("rst_winner", {6'b0, winner}, 8'h00);
        chk("rst_tie", {7'b0, tie}, 8'h00);
        reset = 1'b1;
        @(negedge clock);

        mode = 1'b0;
        c1 = 8'd5;
        report_req = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("mode0_valid", {7'b0, bus.tx_valid}, 8'h00);
            chk("mode0_busy", {7'b0, busy}, 8'h00);
        end
        report_req = 1'b0;
        @(negedge clock);

        frame(8'd3, 8'd7, 8'd2, 8'd7, 56'hA5_03_07_02_07_81_25,
              -1, 0, 1, 2'd1, 1'b1);
        frame(8'd0, 8'd0, 8'd9, 8'd1, 56'hA5_00_00_09_01_02_AF,
              -1, 0, 0, 2'd2, 1'b0);
        frame(8'd3, 8'd7, 8'd2, 8'd7, 56'hA5_03_07_02_07_81_25,
              2, 5, 2, 2'd1, 1'b1);
        frame(8'd0, 8'd0, 8'd0, 8'd0, 56'hA5_00_00_00_00_80_25,
              -1, 0, 0, 2'd0, 1'b1);

        c1 = 8'd9;
        c2 = 8'd8;
        c3 = 8'd7;
        c4 = 8'd6;
        mode = 1'b1;
        report_req = 1'b1;
        @(negedge clock);
        report_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_byte3", bus.tx_data, 8'h07);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {7'b0, bus.tx_valid}, 8'h00);
        chk("arst_busy", {7'b0, busy}, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_valid", {7'b0, bus.tx_valid}, 8'h00);
        chk("rel_winner", {6'b0, winner}, 8'h00);
        chk("rel_tie", {7'b0, tie}, 8'h00);

        frame(8'd1, 8'd2, 8'd3, 8'd4, 56'hA5_01_02_03_04_03_A2,
              -1, 0, 0, 2'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
